// File: rtl/instruction_fetch_pkg.sv
// Definitions shared by the fetch stage and downstream stages: machine-cycle
// phase encodings and the program counter width.
package instruction_fetch_pkg;

    localparam int PC_WIDTH    = 12;
    localparam int PHASE_WIDTH = 3;

    // Phase encodings, numbered 0..7 in cycle order.
    localparam logic [2:0] PHASE_A1 = 3'd0;
    localparam logic [2:0] PHASE_A2 = 3'd1;
    localparam logic [2:0] PHASE_A3 = 3'd2;
    localparam logic [2:0] PHASE_M1 = 3'd3;
    localparam logic [2:0] PHASE_M2 = 3'd4;
    localparam logic [2:0] PHASE_X1 = 3'd5;
    localparam logic [2:0] PHASE_X2 = 3'd6;
    localparam logic [2:0] PHASE_X3 = 3'd7;

    // X3 wraps to A1 through the natural 3-bit overflow.
    function automatic logic [2:0] next_phase(input logic [2:0] phase);
        return phase + 3'd1;
    endfunction

endpackage

// File: rtl/instruction_fetch_sequencer.sv
// Free-running 8-phase machine-cycle counter with decoded phase strobes.
module instruction_fetch_sequencer
    import instruction_fetch_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [2:0] phase,
    output logic       addr_phase,
    output logic       capture_opcode,
    output logic       capture_operand,
    output logic       exec_first,
    output logic       exec_last
);

    always_ff @(posedge clock) begin
        if (reset) begin
            phase <= PHASE_A1;
        end else begin
            phase <= next_phase(phase);
        end
    end

    always_comb begin
        addr_phase      = (phase == PHASE_A1) || (phase == PHASE_A2) || (phase == PHASE_A3);
        capture_opcode  = (phase == PHASE_M1);
        capture_operand = (phase == PHASE_M2);
        exec_first      = (phase == PHASE_X1);
        exec_last       = (phase == PHASE_X3);
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the PC onto the 4-bit bus over A1..A3, captures the
// opcode/operand nibbles in M1/M2, and advances or reloads the PC at X3.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 12'h000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          data_in,
    output logic [3:0]          data_out,
    output logic                data_out_en,
    output logic                sync,
    output logic [2:0]          cycle_phase,
    output logic [PC_WIDTH-1:0] pc,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_load_value,
    output logic [3:0]          inst_opcode,
    output logic [3:0]          inst_operand,
    output logic                inst_valid
);

    logic addr_phase;
    logic capture_opcode;
    logic capture_operand;
    logic exec_first;
    logic exec_last;

    instruction_fetch_sequencer u_sequencer (
        .clock           (clock),
        .reset           (reset),
        .phase           (cycle_phase),
        .addr_phase      (addr_phase),
        .capture_opcode  (capture_opcode),
        .capture_operand (capture_operand),
        .exec_first      (exec_first),
        .exec_last       (exec_last)
    );

    // The PC only moves on the edge leaving X3, so it is stable for a whole cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (exec_last) begin
            pc <= pc_load ? pc_load_value : pc + 12'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            inst_opcode  <= 4'h0;
            inst_operand <= 4'h0;
        end else begin
            if (capture_opcode) begin
                inst_opcode <= data_in;
            end
            if (capture_operand) begin
                inst_operand <= data_in;
            end
        end
    end

    always_comb begin
        data_out = 4'h0;
        case (cycle_phase)
            PHASE_A1: data_out = pc[3:0];
            PHASE_A2: data_out = pc[7:4];
            PHASE_A3: data_out = pc[11:8];
            default:  data_out = 4'h0;
        endcase
    end

    // Reset gates the pulse so a reset landing in X1 never reports an instruction.
    assign data_out_en = addr_phase;
    assign inst_valid  = exec_first && !reset;
    assign sync        = exec_last;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Instruction-cycle sequencer and fetch stage, directly upstream of the datapath/decoder.
- Runs the 8-phase machine cycle: A1 A2 A3 M1 M2 X1 X2 X3.
- Drives the 12-bit program counter onto the 4-bit bus as three nibbles, then captures the returned opcode nibble (OPR) and operand nibble (OPA).
- Presents the captured nibbles as inst_opcode/inst_operand to decode and datapath; inst_operand feeds the datapath operand port directly.

Parameters:
- RESET_PC, 12'h000, PC value loaded on reset.

Ports:
- clock  input  1  system clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  4  bus nibble from program memory; sampled in M1 and M2.
- data_out  output  4  address nibble driven to the bus.
- data_out_en  output  1  high while data_out is valid (A1..A3).
- sync  output  1  high during X3; marks the next cycle as A1.
- cycle_phase  output  3  current phase; encodings from the shared header.
- pc  output  12  address of the instruction being fetched in this machine cycle.
- pc_load  input  1  jump request; honoured only in X3.
- pc_load_value  input  12  jump target.
- inst_opcode  output  4  OPR captured in M1.
- inst_operand  output  4  OPA captured in M2.
- inst_valid  output  1  one-cycle pulse in X1: both nibbles are the new instruction.

Behaviour:
- Reset (synchronous, active-high, any phase, overrides everything):
  - cycle_phase <= A1, pc <= RESET_PC, inst_opcode <= 0, inst_operand <= 0.
  - The first post-reset cycle is A1 fetching RESET_PC.
  - Reset mid-cycle discards the partial fetch; no inst_valid pulse follows.
- Phase counter:
  - Advances one phase per clock: A1->A2->A3->M1->M2->X1->X2->X3->A1. No stalls.
  - cycle_phase is a registered output.
- Bus drive (combinational from phase and pc):
  - A1: data_out = pc[3:0]
  - A2: data_out = pc[7:4]
  - A3: data_out = pc[11:8]
  - data_out_en = 1 in A1..A3, 0 otherwise.
  - data_out = 0 whenever data_out_en = 0.
- Capture:
  - Edge ending M1: inst_opcode <= data_in.
  - Edge ending M2: inst_operand <= data_in.
  - Both registers hold their values until the next M1/M2; X-phase consumers see stable values.
  - data_in is ignored in all other phases.
- Outputs derived from phase:
  - inst_valid = 1 exactly when phase == X1; 0 during reset and in every other phase.
  - sync = 1 exactly when phase == X3.
- PC update, on the edge ending X3 only:
  - pc_load = 1: pc <= pc_load_value.
  - Otherwise: pc <= pc + 1, 12-bit wrap (12'hFFF -> 12'h000).
  - pc_load outside X3 is ignored with no latching; the requester must hold it through X3.
  - pc_load_value = 12'hFFF with load is legal.
  - Load and wrap in the same X3: load wins.
  - pc is constant for all 8 phases of a machine cycle.
- Latency: address to captured instruction is 5 clocks (A1 to X1). Throughput is one instruction per 8 clocks.

Decomposition:
- Shared include fetch.vh holds:
  - PHASE_A1..PHASE_X3 localparams, encoded 0..7 in cycle order.
  - PC_WIDTH = 12.
  - Decode and other stages include it to interpret cycle_phase.
- No sub-module required. Phase counter, PC register and capture registers all live in this module.

Test Plan:
- Reset then run 8 clocks, memory returns OPR=4'hD, OPA=4'h5 -> data_out 0,0,0 in A1..A3 with data_out_en high; inst_valid high only in X1 with inst_opcode=D, inst_operand=5; sync high only in X3; pc=1 at next A1.
- Set pc to 12'h3A7 via load, run one cycle -> data_out sequence 7, A, 3 in A1, A2, A3.
- pc=12'hFFF, no load -> next cycle pc=12'h000.
- pc_load=1, pc_load_value=12'h123 held only in X2 -> ignored, pc increments; same request held in X3 -> next A1 fetches 12'h123.
- Assert reset during M2 with data_in=4'hF -> next cycle is A1 with pc=RESET_PC, inst_operand=0, no inst_valid pulse.
- data_in toggling every cycle outside M1/M2 -> inst_opcode and inst_operand unchanged through X1..X3.
